timer_dev: RTL

- Memory-mapped countdown timer on the data-memory bus, downstream of the single-cycle CPU.
- The CPU's store path (word stores only) writes it; its load path reads it.
- Raises an interrupt request when the count expires.
- Three word registers: CTRL, PRESET, COUNT. Two modes: one-shot and auto-reload.

---
 rtl/timer_dev.sv | 105 ++++++++++
 1 files changed

// File: rtl/timer_dev.sv
// Memory-mapped countdown timer with one-shot and auto-reload modes.
// It raises a level interrupt when the count expires.
module timer_dev #(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

    state_t             state;
    state_t             next_state;
    logic [3:0]         ctrl;
    logic [CNT_W-1:0]   preset;
    logic [CNT_W-1:0]   count;
    logic               flag;

    logic en;
    logic im;
    logic reload;
    logic ctrl_wr;
    logic preset_wr;
    logic expire;

    // MODE 2 and 3 are reserved and fall back to one-shot.
    assign en        = ctrl[0];
    assign im        = ctrl[3];
    assign reload    = (ctrl[2:1] == 2'b01);
    assign ctrl_wr   = we && (addr == 2'd0);
    assign preset_wr = we && (addr == 2'd1);
    assign expire    = (state == CNT) && en && (count <= CNT_W'(1));

    always_ff @(posedge clk) begin
        if (!reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = en ? LOAD : IDLE;
            LOAD:    next_state = en ? CNT : IDLE;
            CNT: begin
                if (!en)
                    next_state = IDLE;
                else if (expire)
                    next_state = INT;
                else
                    next_state = CNT;
            end
            INT:     next_state = reload ? LOAD : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // A CPU write to CTRL is applied last so it wins over the FSM's own updates.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ctrl   <= '0;
            preset <= '0;
            count  <= '0;
            flag   <= 1'b0;
        end else begin
            if (state == LOAD && en)
                count <= preset;
            else if (state == CNT && en)
                count <= expire ? '0 : count - CNT_W'(1);

            if (expire)
                flag <= 1'b1;
            else if (state == INT && reload)
                flag <= 1'b0;

            if (state == INT && !reload)
                ctrl[0] <= 1'b0;

            if (ctrl_wr) begin
                ctrl <= wdata[3:0];
                flag <= 1'b0;
            end

            if (preset_wr)
                preset <= wdata[CNT_W-1:0];
        end
    end

    always_comb begin
        irq = im & flag;
        case (addr)
            2'd0:    rdata = {28'b0, ctrl};
            2'd1:    rdata = 32'(preset);
            2'd2:    rdata = 32'(count);
            default: rdata = 32'b0;
        endcase
    end

endmodule
